instr_fetch: RTL and testbench

Instruction fetch stage of the RISC-V core. Holds the PC, issues in-order word requests to instruction memory, and buffers returned words in a small prefetch FIFO. It presents the words with their PCs to `instr_decoder` under a valid/ready handshake. Jump and branch redirects from downstream flush wrong-path state and restart fetch at the target.

---
 rtl/riscv_pkg.sv | 47 ++++
 rtl/instr_fetch_if.sv | 51 +++++
 rtl/fetch_fifo.sv | 81 ++++++++
 rtl/instr_fetch.sv | 136 +++++++++++++
 tb/tb_instr_fetch.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RISC-V core definitions: data width, default reset PC,
//               the fetch-stage entry type and the base opcode map that the
//               fetch and decode stages agree on.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // RV32I base opcodes (instr[6:0]).
  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b000_0011,
    OPC_MISC_MEM = 7'b000_1111,
    OPC_OP_IMM   = 7'b001_0011,
    OPC_AUIPC    = 7'b001_0111,
    OPC_STORE    = 7'b010_0011,
    OPC_OP       = 7'b011_0011,
    OPC_LUI      = 7'b011_0111,
    OPC_BRANCH   = 7'b110_0011,
    OPC_JALR     = 7'b110_0111,
    OPC_JAL      = 7'b110_1111,
    OPC_SYSTEM   = 7'b111_0011
  } opcode_e;

  // Word-align an address by clearing its two low bits.
  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

  // Sequential next PC; wraps naturally from 32'hFFFF_FFFC to 0.
  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_if
// Description : Bundle of the fetch stage's handshake signals: redirect input
//               from downstream, instruction-memory request/response, and the
//               valid/ready instruction stream to decode.
//               master : the fetch stage
//               slave  : the surroundings (memory, decode, branch unit)
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if;

  // redirect from branch/jump resolution
  logic                          redirect_valid;
  logic [riscv_pkg::XLEN-1:0]    redirect_pc;

  // instruction memory request
  logic                          imem_req_valid;
  logic [riscv_pkg::XLEN-1:0]    imem_req_addr;
  logic                          imem_req_ready;

  // instruction memory response (in order, never back-pressured)
  logic                          imem_rsp_valid;
  logic [riscv_pkg::XLEN-1:0]    imem_rsp_data;

  // instruction stream to decode
  logic                          instr_valid;
  logic [riscv_pkg::XLEN-1:0]    instr;
  logic [riscv_pkg::XLEN-1:0]    instr_pc;
  logic                          instr_ready;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output instr_valid, instr, instr_pc,
    input  instr_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  instr_valid, instr, instr_pc,
    output instr_ready
  );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous FIFO of fetch_entry_t with flush. The head entry
//               is read straight from the storage registers, so a word pushed
//               in one cycle is visible at the output the next cycle.
// Ports       : clk, rst (async, active-high)
//               flush   - empty the FIFO (dominates push/pop)
//               push    - write wr_data (ignored when full unless popping)
//               pop     - drop the head entry (ignored when empty)
//               wr_data / rd_data - entry in / head entry out
//               count, empty, full - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  wire logic                         clk,
  input  wire logic                         rst,
  input  wire logic                         flush,
  input  wire logic                         push,
  input  wire logic                         pop,
  input  wire fetch_entry_t                 wr_data,
  output fetch_entry_t                      rd_data,
  output logic [$clog2(DEPTH+1)-1:0]        count,
  output logic                              empty,
  output logic                              full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t    r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            w_do_push;
  logic            w_do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (r_count == '0);
  assign full    = (r_count == CW'(DEPTH));
  assign count   = r_count;
  assign rd_data = r_mem[r_rd_ptr];

  assign w_do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= wr_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch stage. Holds the fetch PC, issues in-order
//               word requests to instruction memory under a credit limit,
//               buffers returned words with their PCs in a prefetch FIFO and
//               hands them to decode under valid/ready. A redirect flushes
//               wrong-path state and restarts fetch at the target.
// Parameters  : RESET_PC   - first PC fetched after reset
//               FIFO_DEPTH - prefetch entries = max in-flight + buffered words
// Ports       : clk, rst (async, active-high)
//               bus (instr_fetch_if.master) - redirect, imem req/rsp, decode
// Config      : IFETCH_BYPASS_EN - when defined, a response arriving to an
//               empty FIFO is presented to decode in its arrival cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  wire logic          clk,
  input  wire logic          rst,
  instr_fetch_if.master      bus
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0] r_fetch_pc;
  logic [CW-1:0]   r_inflight;   // accepted requests awaiting a response
  logic [CW-1:0]   r_drop;       // in-flight responses belonging to a dead path

  logic [CW-1:0]   w_fifo_count;
  logic            w_fifo_empty;
  logic            w_fifo_full;
  fetch_entry_t    w_fifo_head;
  fetch_entry_t    w_rsp_entry;
  fetch_entry_t    w_out_entry;

  logic [CW:0]     w_occupancy;
  logic            w_credit;
  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_rsp;
  logic            w_rsp_keep;
  logic            w_bypass;
  logic            w_out_valid;
  logic            w_pop;
  logic            w_fifo_pop;
  logic            w_push;

  // --------------------------------------------------------------------------
  // Request side: a request is only offered when the FIFO is guaranteed a
  // slot for its response, so responses never need back-pressure.
  // --------------------------------------------------------------------------
  assign w_occupancy = {1'b0, r_inflight} + {1'b0, w_fifo_count};
  assign w_credit    = (w_occupancy < (CW+1)'(FIFO_DEPTH));
  assign w_req_valid = !rst && !bus.redirect_valid && w_credit;
  assign w_req_fire  = w_req_valid && bus.imem_req_ready;

  // --------------------------------------------------------------------------
  // Response side. When nothing is being dropped, every outstanding request
  // is on the current path and was issued at consecutive word addresses
  // ending just below fetch_pc, so the oldest one's PC is recovered as
  // fetch_pc - 4*inflight instead of being stored in a side queue.
  // --------------------------------------------------------------------------
  assign w_rsp       = bus.imem_rsp_valid;
  assign w_rsp_keep  = w_rsp && (r_drop == '0) && !bus.redirect_valid;
  assign w_rsp_entry = '{pc:    r_fetch_pc - (XLEN'(r_inflight) << 2),
                         instr: bus.imem_rsp_data};

`ifdef IFETCH_BYPASS_EN
  assign w_bypass = !rst && w_fifo_empty && w_rsp_keep;
`else
  assign w_bypass = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Decode side. Redirect masks the output so wrong-path words never leave.
  // --------------------------------------------------------------------------
  assign w_out_valid = !rst && !bus.redirect_valid && (!w_fifo_empty || w_bypass);
  assign w_out_entry = w_bypass ? w_rsp_entry : w_fifo_head;
  assign w_pop       = w_out_valid && bus.instr_ready;
  assign w_fifo_pop  = w_pop && !w_fifo_empty;
  // A bypassed word consumed on arrival is not stored.
  assign w_push      = w_rsp_keep && !(w_bypass && w_pop)
                       && (!w_fifo_full || w_fifo_pop);

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.instr_valid    = w_out_valid;
  assign bus.instr          = w_out_entry.instr;
  assign bus.instr_pc       = w_out_entry.pc;

  // --------------------------------------------------------------------------
  // PC and in-flight bookkeeping. On redirect no request fires, so every
  // request still outstanding after this cycle's response is wrong-path.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_inflight <= '0;
      r_drop     <= '0;
    end else if (bus.redirect_valid) begin
      r_fetch_pc <= pc_align(bus.redirect_pc);
      r_inflight <= r_inflight - CW'(w_rsp);
      r_drop     <= r_inflight - CW'(w_rsp);
    end else begin
      if (w_req_fire) begin
        r_fetch_pc <= pc_next(r_fetch_pc);
      end
      r_inflight <= r_inflight + CW'(w_req_fire) - CW'(w_rsp);
      if (w_rsp && (r_drop != '0)) begin
        r_drop <= r_drop - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (bus.redirect_valid),
    .push    (w_push),
    .pop     (w_fifo_pop),
    .wr_data (w_rsp_entry),
    .rd_data (w_fifo_head),
    .count   (w_fifo_count),
    .empty   (w_fifo_empty),
    .full    (w_fifo_full)
  );

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch. A queue-based model of
//               the fetch stage (outstanding requests, buffered words) and a
//               latency-driven memory model run alongside the DUT; every
//               cycle the DUT outputs are compared with the model's view.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;
  import riscv_pkg::*;

  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int          DEPTH = 2;
`ifdef IFETCH_BYPASS_EN
  localparam bit          BYP   = 1'b1;
`else
  localparam bit          BYP   = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_if bus ();

  instr_fetch #(
    .RESET_PC   (RPC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { logic [31:0] pc; logic [31:0] w; } ent_t;
  typedef struct { logic [31:0] pc; bit drop; }      req_t;
  typedef struct { int due; logic [31:0] addr; }     mem_t;

  ent_t        m_fifo[$];   // words waiting for decode
  req_t        m_fly[$];    // accepted requests, oldest first
  mem_t        mem_q[$];    // memory's pending responses
  logic [31:0] m_pc;
  int          cyc, lat, last_due;
  int          n_vec, n_err;
  int          fires, first_valid;
  logic [31:0] first_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0F0F_3C3C;
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_fly.delete();
    mem_q.delete();
    m_pc     = RPC;
    last_due = -1;
  endtask

  // One clock cycle: drive inputs, compare at the negedge, advance the model.
  task automatic cycle(input bit req_rdy, input bit ins_rdy, input bit redir,
                       input logic [31:0] rpc);
    bit          rsp, e_req, e_val, have_byp;
    logic [31:0] rdata;
    ent_t        e_out;
    req_t        r;
    int          due;

    bus.imem_req_ready = req_rdy;
    bus.instr_ready    = ins_rdy;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    if (rsp) begin
      rdata = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      rdata = $urandom;
    end
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rdata;

    e_req    = !redir && ((m_fly.size() + m_fifo.size()) < DEPTH);
    have_byp = BYP && rsp && !redir && (m_fifo.size() == 0) &&
               (m_fly.size() > 0) && !m_fly[0].drop;
    e_val    = !redir && ((m_fifo.size() > 0) || have_byp);
    if (m_fifo.size() > 0) e_out = m_fifo[0];
    else if (have_byp)     e_out = '{pc: m_fly[0].pc, w: rdata};
    else                   e_out = '{pc: 32'h0, w: 32'h0};

    #4;
    check("req_valid",   32'(bus.imem_req_valid), 32'(e_req));
    check("req_addr",    bus.imem_req_addr, m_pc);
    check("instr_valid", 32'(bus.instr_valid), 32'(e_val));
    if (e_val) begin
      check("instr",    bus.instr,    e_out.w);
      check("instr_pc", bus.instr_pc, e_out.pc);
    end
    if (bus.imem_req_valid && req_rdy) fires++;
    if (first_valid < 0 && bus.instr_valid) begin
      first_valid = cyc;
      first_pc    = bus.instr_pc;
    end

    if (redir) begin
      m_fifo.delete();
      if (rsp) void'(m_fly.pop_front());
      foreach (m_fly[i]) m_fly[i].drop = 1'b1;
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (m_fifo.size() > 0 && ins_rdy) void'(m_fifo.pop_front());
      if (rsp) begin
        r = m_fly.pop_front();
        if (!r.drop && !(have_byp && ins_rdy)) m_fifo.push_back('{pc: r.pc, w: rdata});
      end
      if (e_req && req_rdy) begin
        m_fly.push_back('{pc: m_pc, drop: 1'b0});
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_q.push_back('{due: due, addr: m_pc});
        m_pc = m_pc + 32'd4;
      end
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_valid"},   32'(bus.imem_req_valid), 32'h0);
    check({tag, "_req_addr"},    bus.imem_req_addr, RPC);
    check({tag, "_instr_valid"}, 32'(bus.instr_valid), 32'h0);
    check({tag, "_instr"},       bus.instr, 32'h0);
    check({tag, "_instr_pc"},    bus.instr_pc, 32'h0);
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; lat = 1; fires = 0;
    first_valid = -1; first_pc = '0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;   bus.instr_ready = 1'b0;
    model_reset();

    // reset state
    @(posedge clk); #1; #1;
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // streaming at L=1
    cyc = 0;
    repeat (14) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("first_valid_cyc", 32'(first_valid), BYP ? 32'd1 : 32'd2);
    check("first_valid_pc",  first_pc, RPC);

    // decode stalled: only the credit's worth of requests may fire
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0300);
    fires = 0;
    repeat (10) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("stall_fires", 32'(fires), 32'd2);
    repeat (8) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // L=3: two requests in flight, then redirect to 0x200
    lat = 3;
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0400);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    first_valid = -1;
    repeat (14) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("redir_first_pc", first_pc, 32'h0000_0200);

    // redirect coinciding with a response, then the wrap-around target
    lat = 1;
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
    repeat (8) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      lat = $urandom_range(1, 4);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0, $urandom);
    end

    // reset with the FIFO full
    lat = 1;
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0040);
    repeat (6) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("full_before_rst", 32'(m_fifo.size()), 32'(DEPTH));
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    bus.imem_rsp_valid = 1'b0;
    bus.redirect_valid = 1'b0;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc = 0;
    first_valid = -1;
    repeat (10) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("rst_first_valid_cyc", 32'(first_valid), BYP ? 32'd1 : 32'd2);
    check("rst_first_pc", first_pc, RPC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
